fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of the team's async FIFO among NUM_REQ producers in the write clock domain. Each producer offers words with a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's write_enable and write_data. It honours write_full, keeps a saturating count of cycles stalled on full, and sits directly in front of the FIFO write side.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_write_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e    : arbiter FSM states
//   safe_clog2()   : index width that never collapses to zero bits
//   DefaultStallW  : default width of the stall counter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } arb_state_e;

  localparam int unsigned DefaultStallW = 16;

  // A single-entry index still needs one bit of storage.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req_i    : request vector
//   ptr_i    : highest-priority index; search runs upward from here and wraps
//   onehot_o : winner as a one-hot vector (zero when nothing requests)
//   idx_o    : winner index
//   any_o    : at least one request is set
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] onehot_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    onehot_o = '0;
    idx_o    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      // Modulo rather than natural wrap so non-power-of-two counts work.
      cand = IdxW'((32'(ptr_i) + k) % NumReq);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers.
//   write_clk_i      : write-domain clock
//   write_reset_i    : asynchronous active-high reset
//   req_valid_i      : per-requester word valid
//   req_data_i       : packed request words, requester i at [i*DATASIZE +: DATASIZE]
//   req_ready_o      : per-requester accept (one-hot or zero)
//   write_full_i     : FIFO full flag
//   write_enable_o   : FIFO write strobe
//   write_data_o     : FIFO write data
//   grant_valid_o    : a requester holds the grant
//   grant_id_o       : index of the granted requester
//   stall_count_o    : saturating count of granted cycles blocked by write_full_i
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATASIZE  = 12,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned STALL_W   = DefaultStallW,
  localparam int unsigned IdxW     = safe_clog2(NUM_REQ)
) (
  input  logic                         write_clk_i,
  input  logic                         write_reset_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATASIZE-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic                         write_full_i,
  output logic                         write_enable_o,
  output logic [DATASIZE-1:0]          write_data_o,
  output logic                         grant_valid_o,
  output logic [IdxW-1:0]              grant_id_o,
  output logic [STALL_W-1:0]           stall_count_o
);

  localparam int unsigned     BeatW    = $clog2(MAX_BURST) + 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(MAX_BURST - 1);

  arb_state_e           state_q, state_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [IdxW-1:0]      grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic [STALL_W-1:0]   stall_q, stall_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;

  rr_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  logic                in_burst;
  logic                g_valid;
  logic [DATASIZE-1:0] g_data;
  logic [IdxW-1:0]     next_ptr;

  assign in_burst = (state_q == StBurst);
  // One-hot grant mask keeps valid/ready gating free of a decoder.
  assign g_valid  = |(req_valid_i & grant_oh_q);
  assign next_ptr = (grant_id_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    g_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IdxW'(i)) g_data = req_data_i[i*DATASIZE +: DATASIZE];
    end
  end

  // Everything here derives from reset-cleared state, so it is all-zero in reset.
  assign req_ready_o    = in_burst ? (grant_oh_q & {NUM_REQ{~write_full_i}}) : '0;
  assign write_enable_o = in_burst & g_valid & ~write_full_i;
  assign write_data_o   = grant_valid_q ? g_data : '0;
  assign grant_valid_o  = grant_valid_q;
  assign grant_id_o     = grant_id_q;
  assign stall_count_o  = stall_q;

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    grant_oh_d    = grant_oh_q;
    ptr_d         = ptr_q;
    beat_d        = beat_q;
    stall_d       = stall_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d       = StBurst;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_idx;
          grant_oh_d    = pick_onehot;
          beat_d        = '0;
        end
      end
      StBurst: begin
        if (!g_valid) begin
          // Dropping valid forfeits the grant.
          state_d       = StIdle;
          grant_valid_d = 1'b0;
          grant_oh_d    = '0;
          ptr_d         = next_ptr;
          beat_d        = '0;
        end else if (write_full_i) begin
          if (stall_q != '1) stall_d = stall_q + 1'b1;
        end else if (beat_q == LastBeat) begin
          state_d       = StIdle;
          grant_valid_d = 1'b0;
          grant_oh_d    = '0;
          ptr_d         = next_ptr;
          beat_d        = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge write_clk_i or posedge write_reset_i) begin
    if (write_reset_i) begin
      state_q       <= StIdle;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      grant_oh_q    <= '0;
      ptr_q         <= '0;
      beat_q        <= '0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      grant_oh_q    <= grant_oh_d;
      ptr_q         <= ptr_d;
      beat_q        <= beat_d;
      stall_q       <= stall_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus a random
// phase, all compared cycle by cycle against a rule-level reference model.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 12;
  localparam int MB = 4;
  localparam int STALL_MAX = 65535;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     valid;
  logic [NR*DW-1:0]  data;
  logic              full;
  logic [NR-1:0]     ready;
  logic              we;
  logic [DW-1:0]     wdata;
  logic              gv;
  logic [1:0]        gid;
  logic [15:0]       stall;

  fifo_write_arbiter dut (
    .write_clk_i    (clk),
    .write_reset_i  (rst),
    .req_valid_i    (valid),
    .req_data_i     (data),
    .req_ready_o    (ready),
    .write_full_i   (full),
    .write_enable_o (we),
    .write_data_o   (wdata),
    .grant_valid_o  (gv),
    .grant_id_o     (gid),
    .stall_count_o  (stall)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the port, how many words it has moved, where the
  // next search starts, and the stall tally.
  bit m_busy;
  int m_gid;
  int m_ptr;
  int m_words;
  int m_stall;

  // Requester side of the bench.
  int          pend [NR];
  logic [NR-1:0] acc;
  bit          rand_mode;
  int          n_writes;
  int          grants [$];
  bit          prev_gv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_gid = 0; m_ptr = 0; m_words = 0; m_stall = 0;
  endfunction

  function automatic void model_advance();
    if (!m_busy) begin
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (valid[c]) begin
          m_busy = 1; m_gid = c; m_words = 0;
          break;
        end
      end
    end else if (!valid[m_gid]) begin
      m_busy = 0; m_ptr = (m_gid + 1) % NR;
    end else if (full) begin
      if (m_stall < STALL_MAX) m_stall++;
    end else begin
      m_words++;
      if (m_words == MB) begin
        m_busy = 0; m_ptr = (m_gid + 1) % NR;
      end
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        pend[i]--;
        data[i*DW +: DW] = DW'($urandom);
        valid[i] = 1'b0;
      end
      if (rand_mode) begin
        if (valid[i] && $urandom_range(0, 15) == 0) valid[i] = 1'b0;
        else if (!valid[i] && pend[i] > 0 && $urandom_range(0, 2) != 0) valid[i] = 1'b1;
      end else begin
        valid[i] = (pend[i] > 0);
      end
    end
    acc = '0;
    if (rand_mode) full = ($urandom_range(0, 3) == 0);
  endtask

  // One clock: check outputs at the falling edge, advance the model, then
  // update requesters just after the rising edge.
  task automatic step();
    logic [NR-1:0] e_ready;
    logic          e_we;
    logic [DW-1:0] e_data;
    @(negedge clk);
    e_ready = '0; e_we = 1'b0; e_data = '0;
    if (m_busy) begin
      if (!full) e_ready[m_gid] = 1'b1;
      e_we   = valid[m_gid] & ~full;
      e_data = data[m_gid*DW +: DW];
    end
    chk("grant_valid", 64'(gv), 64'(m_busy));
    if (m_busy) chk("grant_id", 64'(gid), 64'(m_gid));
    chk("req_ready", 64'(ready), 64'(e_ready));
    chk("write_enable", 64'(we), 64'(e_we));
    chk("write_data", 64'(wdata), 64'(e_data));
    chk("stall_count", 64'(stall), 64'(m_stall));
    if (we) n_writes++;
    if (gv && !prev_gv) grants.push_back(int'(gid));
    prev_gv = gv;
    acc = valid & ready;
    model_advance();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = '0; full = 1'b0; acc = '0; rand_mode = 0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0;
      data[i*DW +: DW] = DW'($urandom);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_writes = 0; prev_gv = 0;
    grants.delete();
  endtask

  initial begin
    rst = 1'b1; valid = '0; full = 1'b0; data = '0; acc = '0;

    // Reset values.
    do_reset();
    @(negedge clk);
    chk("rst_grant_valid", 64'(gv), 64'd0);
    chk("rst_grant_id", 64'(gid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;

    // 1: async reset mid-burst with req0 at beat 2.
    do_reset();
    pend[0] = 10; drive();
    repeat (3) step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t1_grant_valid", 64'(gv), 64'd0);
    chk("t1_req_ready", 64'(ready), 64'd0);
    chk("t1_write_enable", 64'(we), 64'd0);
    chk("t1_write_data", 64'(wdata), 64'd0);
    chk("t1_stall", 64'(stall), 64'd0);
    pend[0] = 0; valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) step();
    chk("t1_stays_idle", 64'(gv), 64'd0);

    // 2: req2 alone with 6 words; 4 + bubble + 2.
    do_reset();
    pend[2] = 6; drive();
    repeat (10) step();
    chk("t2_writes", 64'(n_writes), 64'd6);
    chk("t2_grants", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) begin
      chk("t2_first_grant", 64'(grants[0]), 64'd2);
      chk("t2_regrant", 64'(grants[1]), 64'd2);
    end

    // 3: all requesters valid; 16 writes in 20 cycles, order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NR; i++) pend[i] = 8;
    drive();
    repeat (20) step();
    chk("t3_writes_20cyc", 64'(n_writes), 64'd16);
    repeat (2) step();
    chk("t3_grants", 64'(grants.size()), 64'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("t3_order", 64'(grants[i]), 64'(i % NR));

    // 4: req1 stalled 3 cycles after its first word.
    do_reset();
    pend[1] = 4; drive();
    repeat (2) step();
    full = 1'b1;
    repeat (3) step();
    chk("t4_stall", 64'(stall), 64'd3);
    chk("t4_writes_before", 64'(n_writes), 64'd1);
    full = 1'b0;
    repeat (4) step();
    chk("t4_writes_total", 64'(n_writes), 64'd4);
    chk("t4_released", 64'(gv), 64'd0);

    // 5: req3 sends 2 words then drops; req0 wins after one bubble.
    do_reset();
    pend[3] = 2; drive();
    repeat (3) step();
    pend[0] = 2; drive();
    step();
    chk("t5_bubble", 64'(gv), 64'd0);
    step();
    chk("t5_next_valid", 64'(gv), 64'd1);
    chk("t5_next_id", 64'(gid), 64'd0);
    repeat (3) step();

    // Random phase.
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < NR; i++) pend[i] = 1000;
    repeat (400) step();
    rand_mode = 0;

    // 6: long stall saturates the counter without any write strobe.
    do_reset();
    pend[0] = 1; full = 1'b1; drive();
    repeat (70000) step();
    chk("t6_stall_sat", 64'(stall), 64'(STALL_MAX));
    chk("t6_no_writes", 64'(n_writes), 64'd0);
    full = 1'b0;
    repeat (2) step();
    chk("t6_write_after", 64'(n_writes), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
